// File: rtl/seq_pattern_ctrl.sv
// ============================================================================
// Module   : seq_pattern_ctrl
// Brief    : Table-driven pattern sequencer with dwell, loop, stop and
//            config-write guard. Optional SEQ_PAUSE_EN adds a pause input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_pattern_ctrl #(
   parameter int DEPTH   = 4,
   parameter int VAL_W   = 3,
   parameter int DWELL_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [$clog2(DEPTH)-1:0] cfg_addr,
   input  logic [VAL_W-1:0]         cfg_data,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     loop,
   input  logic [DWELL_W-1:0]       dwell,
`ifdef SEQ_PAUSE_EN
   input  logic                     pause,
`endif
   output logic [VAL_W-1:0]         count,
   output logic [$clog2(DEPTH)-1:0] step_idx,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q;
   logic [VAL_W-1:0]     table_q [DEPTH];
   logic [VAL_W-1:0]     count_q;
   logic [AW-1:0]        idx_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 cfg_err_q;
   logic [DWELL_W-1:0]   dwell_cnt_q;
   logic [DWELL_W-1:0]   dwell_q;
   logic                 loop_q;
   logic [AW-1:0]        idx_d;
   logic [VAL_W-1:0]     first_val_d;
   logic                 hold_d;

   function automatic logic [VAL_W-1:0] reset_val(input int i);
      case (i)
         1:       return VAL_W'(2);
         2:       return VAL_W'(3);
         3:       return VAL_W'(7);
         default: return '0;
      endcase
   endfunction

   assign idx_d = idx_q + 1'b1;
   // A write issued alongside start lands before the run reads entry 0.
   assign first_val_d = (cfg_we && (cfg_addr == '0)) ? cfg_data : table_q[0];

`ifdef SEQ_PAUSE_EN
   assign hold_d = pause;
`else
   assign hold_d = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
         dwell_cnt_q <= '0;
         dwell_q     <= '0;
         loop_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= reset_val(i);
         end
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_we) begin
                  table_q[cfg_addr] <= cfg_data;
               end
               if (start) begin
                  state_q     <= RUN;
                  loop_q      <= loop;
                  dwell_q     <= dwell;
                  dwell_cnt_q <= dwell;
                  idx_q       <= '0;
                  count_q     <= first_val_d;
                  busy_q      <= 1'b1;
               end
            end
            RUN: begin
               cfg_err_q <= cfg_we;
               if (stop) begin
                  state_q     <= IDLE;
                  count_q     <= '0;
                  idx_q       <= '0;
                  busy_q      <= 1'b0;
                  dwell_cnt_q <= '0;
               end else if (hold_d) begin
                  state_q <= RUN;
               end else if (dwell_cnt_q != '0) begin
                  dwell_cnt_q <= dwell_cnt_q - 1'b1;
               end else if (idx_q != LAST_IDX) begin
                  idx_q       <= idx_d;
                  count_q     <= table_q[idx_d];
                  dwell_cnt_q <= dwell_q;
               end else if (loop_q) begin
                  idx_q       <= '0;
                  count_q     <= table_q[0];
                  dwell_cnt_q <= dwell_q;
               end else begin
                  state_q <= IDLE;
                  count_q <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign count    = count_q;
   assign step_idx = idx_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign cfg_err  = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_ctrl.sv
// ============================================================================
// Module   : tb_seq_pattern_ctrl
// Brief    : Self-checking bench for seq_pattern_ctrl (DEPTH=4, VAL_W=3).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_ctrl;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = '0;
   logic [2:0] cfg_data = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       loop = 1'b0;
   logic [3:0] dwell = '0;
   logic       pause = 1'b0;
   logic [2:0] count;
   logic [1:0] step_idx;
   logic       busy;
   logic       done;
   logic       cfg_err;

   int checks = 0;
   int errors = 0;
   logic [2:0] model_tbl [DEPTH];

   seq_pattern_ctrl #(.DEPTH(4), .VAL_W(3), .DWELL_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .start    (start),
      .stop     (stop),
      .loop     (loop),
      .dwell    (dwell),
`ifdef SEQ_PAUSE_EN
      .pause    (pause),
`endif
      .count    (count),
      .step_idx (step_idx),
      .busy     (busy),
      .done     (done),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      model_tbl[0] = 3'd0; model_tbl[1] = 3'd2;
      model_tbl[2] = 3'd3; model_tbl[3] = 3'd7;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_idx"},   32'(step_idx), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_done"},  32'(done), 32'd0);
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [2:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      tick();
      cfg_we = 1'b0;
      model_tbl[a] = d;
      chk("idle_wr_cfg_err", 32'(cfg_err), 32'd0);
   endtask

   // Non-loop run: trace is each entry repeated dwell+1 times, then one done cycle.
   // Returns while the done cycle is visible.
   task automatic run_check(input string tag, input int d, input bit ws, input logic [1:0] wa,
                            input logic [2:0] wd, input bit sws, input bit midwr);
      int q_cnt[$];
      int q_idx[$];
      if (ws) model_tbl[wa] = wd;
      for (int k = 0; k < DEPTH; k++)
         for (int r = 0; r <= d; r++) begin
            q_cnt.push_back(int'(model_tbl[k]));
            q_idx.push_back(k);
         end
      cfg_we = ws; cfg_addr = wa; cfg_data = wd;
      start = 1'b1; stop = sws; dwell = 4'(d); loop = 1'b0;
      tick();
      start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
      dwell = 4'($urandom); loop = 1'($urandom);
      for (int i = 0; i < q_cnt.size(); i++) begin
         chk({tag, "_count"}, 32'(count), 32'(q_cnt[i]));
         chk({tag, "_idx"},   32'(step_idx), 32'(q_idx[i]));
         chk({tag, "_busy"},  32'(busy), 32'd1);
         chk({tag, "_done"},  32'(done), 32'd0);
         chk({tag, "_cfg_err"}, 32'(cfg_err), 32'(midwr && i == 2));
         if (midwr && i == 1) begin
            cfg_we = 1'b1; cfg_addr = 2'($urandom); cfg_data = 3'($urandom);
         end
         tick();
         cfg_we = 1'b0;
      end
      chk({tag, "_end_done"},  32'(done), 32'd1);
      chk({tag, "_end_busy"},  32'(busy), 32'd0);
      chk({tag, "_end_count"}, 32'(count), 32'd0);
      chk({tag, "_end_idx"},   32'(step_idx), 32'd0);
   endtask

   initial begin
      model_reset();
      // Reset values while held in reset
      #12;
      chk_idle("rst");
      chk("rst_cfg_err", 32'(cfg_err), 32'd0);
      @(negedge clk); rst = 1'b1;
      tick();
      chk_idle("post_rst");

      // Default run, then dwell=2
      run_check("run_d0", 0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
      tick(); chk_idle("after_d0");
      run_check("run_d2", 2, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
      tick(); chk_idle("after_d2");

      // Stop in IDLE is ignored
      stop = 1'b1; tick(); stop = 1'b0;
      chk_idle("stop_idle");

      // Loop run, stop on the second pass at value 2
      start = 1'b1; loop = 1'b1; dwell = 4'd0;
      tick();
      start = 1'b0; loop = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("loop_count", 32'(count), 32'(model_tbl[k % DEPTH]));
         chk("loop_busy", 32'(busy), 32'd1);
         chk("loop_done", 32'(done), 32'd0);
         if (k < 5) tick();
      end
      stop = 1'b1; tick(); stop = 1'b0;
      chk_idle("loop_stop");
      tick();
      chk_idle("loop_stop2");

      // Config write in IDLE, then a dropped write during a run
      cfg_write(2'd2, 3'd5);
      run_check("cfg_run", 0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
      tick(); chk_idle("after_cfg");
      run_check("cfg_run2", 0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);

      // Earliest restart: start sampled during the done cycle
      start = 1'b1; dwell = 4'd0;
      tick();
      start = 1'b0;
      chk("restart_busy", 32'(busy), 32'd1);
      chk("restart_count", 32'(count), 32'(model_tbl[0]));
      stop = 1'b1; tick(); stop = 1'b0;
      chk_idle("restart_stop");

      // Randomized runs: writes, simultaneous write/stop with start, mid-run writes
      for (int n = 0; n < 8; n++) begin
         int nw;
         nw = int'($urandom_range(2, 0));
         for (int w = 0; w < nw; w++) cfg_write(2'($urandom), 3'($urandom));
         run_check("rand", int'($urandom_range(3, 0)), 1'($urandom), 2'($urandom),
                   3'($urandom), 1'($urandom), 1'($urandom));
         tick(); chk_idle("rand_after");
      end

      // Async reset mid-run during entry 2 restores the table
      cfg_write(2'd2, 3'd5);
      start = 1'b1; dwell = 4'd1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("arst_pre_count", 32'(count), 32'd5);
      #2 rst = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      @(negedge clk); rst = 1'b1;
      model_reset();
      tick(); chk_idle("arst_idle");
      run_check("arst_run", 0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
      tick();

`ifdef SEQ_PAUSE_EN
      // Pause for three cycles while count=3
      start = 1'b1; dwell = 4'd0;
      tick(); start = 1'b0;
      tick(); tick();
      chk("pause_c3", 32'(count), 32'd3);
      pause = 1'b1;
      repeat (3) begin
         tick();
         chk("pause_hold", 32'(count), 32'd3);
         chk("pause_busy", 32'(busy), 32'd1);
      end
      pause = 1'b0;
      tick(); chk("pause_c7", 32'(count), 32'd7);
      tick(); chk("pause_done", 32'(done), 32'd1);
      tick();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
